// File: rtl/pmp_csr_file.sv
// Machine-mode PMP CSR storage: pmpcfg0-3 and pmpaddr0-15 with lock and WARL handling.
// Drives packed cfg/addr images to the PMP checker and pulses cfg_update after any change.
module pmp_csr_file #(
  parameter int NUM_ENTRIES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         csr_valid,
  input  logic [11:0]  csr_addr,
  input  logic [1:0]   csr_op,
  input  logic [31:0]  csr_wdata,
  input  logic [1:0]   prive_mode,
  output logic         csr_hit,
  output logic [31:0]  csr_rdata,
  output logic         csr_illegal,
  output logic [127:0] pmpcfg_o,
  output logic [511:0] pmpaddr_o,
  output logic         cfg_update
);

  logic [127:0] cfg_q, cfg_d;
  logic [511:0] addr_q, addr_d;
  logic         update_q;
  logic         hit_cfg, hit_addr, commit;
  logic [1:0]   cfg_idx;
  logic [3:0]   addr_idx;
  logic [31:0]  old_val, new_val;
  logic [15:0]  next_tor_locked;

  // A locked byte, an R=0/W=1 combination or the unsupported NA4 mode all leave the byte as it was.
  function automatic logic [7:0] cfg_byte_next(input logic [7:0] cur, input logic [7:0] nxt);
    logic [7:0] res;
    res = cur;
    if (!cur[7] && !(!nxt[0] && nxt[1]) && (nxt[4:3] != 2'b10))
      res = {nxt[7], 2'b00, nxt[4:0]};
    return res;
  endfunction

  assign hit_cfg     = (csr_addr[11:2] == 10'h0E8);
  assign hit_addr    = (csr_addr[11:4] == 8'h3B);
  assign cfg_idx     = csr_addr[1:0];
  assign addr_idx    = csr_addr[3:0];
  assign csr_hit     = hit_cfg | hit_addr;
  assign csr_illegal = csr_valid & csr_hit & (prive_mode != 2'b11);
  assign commit      = csr_valid & csr_hit & ~csr_illegal & (csr_op != 2'b00);

  always_comb begin
    old_val = '0;
    if (hit_cfg)
      old_val = cfg_q[32*cfg_idx +: 32];
    else if (hit_addr)
      old_val = addr_q[32*addr_idx +: 32];
  end

  assign csr_rdata = (csr_hit & ~csr_illegal) ? old_val : 32'h0;

  always_comb begin
    new_val = old_val;
    case (csr_op)
      2'b01:   new_val = csr_wdata;
      2'b10:   new_val = old_val | csr_wdata;
      2'b11:   new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase
  end

  // Entry N+1 being a locked TOR entry protects pmpaddrN, its lower bound.
  always_comb begin
    next_tor_locked = '0;
    for (int i = 0; i < 15; i++)
      next_tor_locked[i] = cfg_q[8*(i+1)+7] & (cfg_q[8*(i+1)+3 +: 2] == 2'b01);
  end

  always_comb begin
    cfg_d  = cfg_q;
    addr_d = addr_q;
    for (int i = 0; i < 16; i++) begin
      if (commit && hit_cfg && (i < NUM_ENTRIES) && (int'(cfg_idx) == i / 4))
        cfg_d[8*i +: 8] = cfg_byte_next(cfg_q[8*i +: 8], new_val[8*(i%4) +: 8]);
      if (commit && hit_addr && (i < NUM_ENTRIES) && (int'(addr_idx) == i) &&
          !cfg_q[8*i+7] && !next_tor_locked[i])
        addr_d[32*i +: 32] = new_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q    <= '0;
      addr_q   <= '0;
      update_q <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      addr_q   <= addr_d;
      update_q <= (cfg_d != cfg_q) || (addr_d != addr_q);
    end
  end

  assign pmpcfg_o   = cfg_q;
  assign pmpaddr_o  = addr_q;
  assign cfg_update = update_q;

endmodule

// File: tb/tb_pmp_csr_file.sv
// Self-checking bench for pmp_csr_file: directed scenarios then random CSR traffic
// compared against an array-based reference model of the PMP CSR rules.
module tb_pmp_csr_file;
  localparam int NUM = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         csr_valid = 1'b0;
  logic [11:0]  csr_addr = '0;
  logic [1:0]   csr_op = '0;
  logic [31:0]  csr_wdata = '0;
  logic [1:0]   prive_mode = 2'b11;
  logic         csr_hit, csr_illegal, cfg_update;
  logic [31:0]  csr_rdata;
  logic [127:0] pmpcfg_o;
  logic [511:0] pmpaddr_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  m_cfg [16];
  logic [31:0] m_addr [16];
  logic        exp_update;

  pmp_csr_file #(.NUM_ENTRIES(NUM)) dut (
    .clk(clk), .rst_n(rst_n), .csr_valid(csr_valid), .csr_addr(csr_addr),
    .csr_op(csr_op), .csr_wdata(csr_wdata), .prive_mode(prive_mode),
    .csr_hit(csr_hit), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .pmpcfg_o(pmpcfg_o), .pmpaddr_o(pmpaddr_o), .cfg_update(cfg_update)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic m_hit(input logic [11:0] a);
    return (a >= 12'h3A0 && a <= 12'h3A3) || (a >= 12'h3B0 && a <= 12'h3BF);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    logic [31:0] v;
    int k, e;
    v = '0;
    if (a >= 12'h3A0 && a <= 12'h3A3) begin
      k = int'(a) - 'h3A0;
      for (int b = 0; b < 4; b++) begin
        e = 4 * k + b;
        if (e < NUM) v[8*b +: 8] = m_cfg[e];
      end
    end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
      k = int'(a) - 'h3B0;
      if (k < NUM) v = m_addr[k];
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_cfg[i]  = 8'h00;
      m_addr[i] = 32'h0;
    end
    exp_update = 1'b0;
  endtask

  task automatic model_commit(input logic [11:0] a, input logic [1:0] op,
                              input logic [31:0] wd, output logic changed);
    logic [31:0] old_v, new_v;
    logic [7:0]  ob, nb;
    int k, e;
    changed = 1'b0;
    if (!m_hit(a) || op == 2'b00) return;
    old_v = m_read(a);
    case (op)
      2'b01:   new_v = wd;
      2'b10:   new_v = old_v | wd;
      default: new_v = old_v & ~wd;
    endcase
    if (a < 12'h3B0) begin
      k = int'(a) - 'h3A0;
      for (int b = 0; b < 4; b++) begin
        e = 4 * k + b;
        if (e >= NUM) continue;
        ob = m_cfg[e];
        nb = new_v[8*b +: 8];
        if (ob[7]) continue;
        if (!nb[0] && nb[1]) continue;
        if (nb[4:3] == 2'b10) continue;
        nb[6:5] = 2'b00;
        if (nb != ob) changed = 1'b1;
        m_cfg[e] = nb;
      end
    end else begin
      k = int'(a) - 'h3B0;
      if (k < NUM && !m_cfg[k][7] &&
          !((k + 1 < NUM) && m_cfg[k+1][7] && m_cfg[k+1][4:3] == 2'b01)) begin
        if (m_addr[k] != new_v) changed = 1'b1;
        m_addr[k] = new_v;
      end
    end
  endtask

  task automatic check_state(input string tag);
    logic [127:0] cv;
    logic [511:0] av;
    for (int i = 0; i < 16; i++) begin
      cv[8*i +: 8]  = m_cfg[i];
      av[32*i +: 32] = m_addr[i];
    end
    checkOutput({tag, "_pmpcfg"}, pmpcfg_o, cv);
    checkOutput({tag, "_pmpaddr"}, pmpaddr_o, av);
    checkOutput({tag, "_update"}, cfg_update, exp_update);
  endtask

  task automatic applyStimulus(input logic v, input logic [11:0] a, input logic [1:0] op,
                               input logic [31:0] wd, input logic [1:0] mode);
    logic is_hit, ill, ch;
    @(negedge clk);
    csr_valid = v; csr_addr = a; csr_op = op; csr_wdata = wd; prive_mode = mode;
    #1;
    is_hit = m_hit(a);
    ill = v && is_hit && (mode != 2'b11);
    checkOutput("hit", csr_hit, is_hit);
    checkOutput("illegal", csr_illegal, ill);
    checkOutput("rdata", csr_rdata, (is_hit && !ill) ? m_read(a) : 32'h0);
    ch = 1'b0;
    if (v && !ill) model_commit(a, op, wd, ch);
    @(posedge clk);
    #1;
    exp_update = ch;
    check_state("post");
  endtask

  task automatic resetMidOp();
    @(negedge clk);
    csr_valid = 1'b1; csr_addr = 12'h3B3; csr_op = 2'b01;
    csr_wdata = 32'hDEAD_BEEF; prive_mode = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_cfg", pmpcfg_o, 128'h0);
    checkOutput("rst_async_addr", pmpaddr_o, 512'h0);
    checkOutput("rst_async_update", cfg_update, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    check_state("rst_hold");
    @(negedge clk);
    csr_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] wd;
    logic [1:0]  mode;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, 12'h3A0, 2'b00, 32'h0, 2'b11);
    applyStimulus(1'b1, 12'h3BF, 2'b00, 32'h0, 2'b11);

    applyStimulus(1'b1, 12'h3A0, 2'b01, 32'h0000_0F0F, 2'b11);
    checkOutput("cfg_0f0f", pmpcfg_o[15:0], 16'h0F0F);
    checkOutput("update_pulse", cfg_update, 1'b1);
    applyStimulus(1'b1, 12'h3A0, 2'b01, 32'h0000_0F0F, 2'b11);
    checkOutput("update_nochange", cfg_update, 1'b0);

    applyStimulus(1'b1, 12'h3A0, 2'b01, 32'h0000_0062, 2'b11);
    checkOutput("warl_rw_byte0", pmpcfg_o[7:0], 8'h0F);
    applyStimulus(1'b1, 12'h3A0, 2'b01, 32'h0000_0067, 2'b11);
    checkOutput("reserved_zero", pmpcfg_o[31:0], 32'h0000_0007);
    applyStimulus(1'b1, 12'h3A0, 2'b01, 32'h0000_0013, 2'b11);
    checkOutput("na4_rejected", pmpcfg_o[7:0], 8'h07);

    applyStimulus(1'b1, 12'h3B0, 2'b01, 32'h2000_0000, 2'b11);
    applyStimulus(1'b1, 12'h3A0, 2'b01, 32'h0000_8900, 2'b11);
    checkOutput("lock_byte1", pmpcfg_o[15:8], 8'h89);
    applyStimulus(1'b1, 12'h3B0, 2'b01, 32'h1234_5678, 2'b11);
    checkOutput("tor_protect_addr0", pmpaddr_o[31:0], 32'h2000_0000);
    applyStimulus(1'b1, 12'h3B1, 2'b01, 32'hABCD_0000, 2'b11);
    checkOutput("lock_protect_addr1", pmpaddr_o[63:32], 32'h0);
    applyStimulus(1'b1, 12'h3A0, 2'b11, 32'hFFFF_FFFF, 2'b11);
    checkOutput("clear_keeps_lock", pmpcfg_o[15:0], 16'h8900);

    applyStimulus(1'b1, 12'h3B2, 2'b01, 32'h5555_AAAA, 2'b00);
    checkOutput("umode_addr2", pmpaddr_o[95:64], 32'h0);

    applyStimulus(1'b1, 12'h3B5, 2'b10, 32'h0000_00F0, 2'b11);
    applyStimulus(1'b1, 12'h3B5, 2'b11, 32'h0000_0030, 2'b11);
    checkOutput("setclear_addr5", pmpaddr_o[191:160], 32'h0000_00C0);
    applyStimulus(1'b0, 12'h000, 2'b00, 32'h0, 2'b11);

    resetMidOp();

    for (int it = 0; it < 600; it++) begin
      if (it % 60 == 59) resetMidOp();
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 12'h3A0 + 12'($urandom_range(0, 3));
        4, 5, 6, 7, 8: a = 12'h3B0 + 12'($urandom_range(0, 15));
        default: a = 12'($urandom);
      endcase
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) wd = wd & 32'h7F7F_7F7F;
      mode = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
      applyStimulus(1'($urandom_range(0, 7) != 0), a, 2'($urandom), wd, mode);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
